// File: rtl/psk_modulator.sv
// BPSK byte transmitter: alternating-phase preamble, then LSB-first data.
// Define PSK_DIFF_EN for differential phase encoding (absolute otherwise).
module psk_modulator #(
    parameter int HALF_PERIOD    = 5,
    parameter int CYCLES_PER_SYM = 2,
    parameter int PREAMBLE_SYMS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       psk_signal,
    output logic       busy,
    output logic       sym_strobe
);

    localparam int SYM_LEN = 2 * HALF_PERIOD * CYCLES_PER_SYM;
    localparam int SW = $clog2(SYM_LEN);
    localparam int PW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
    localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_SYMS - 1);
    localparam logic [SW-1:0] HP = SW'(HALF_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA
    } state_t;

    state_t        state, next_state;
    logic [SW-1:0] sym_cnt, next_sym_cnt;
    logic [PW-1:0] pre_cnt, next_pre_cnt;
    logic [2:0]    bit_idx, next_bit_idx;
    logic          phase, next_phase;
    logic [7:0]    shreg, next_shreg;

    logic       sym_end;
    logic       accept;
    logic       upd;
    logic       b_next;
    logic       next_carrier;
    logic [2:0] bit_nx;

    assign busy       = (state != IDLE);
    assign sym_strobe = busy && (sym_cnt == '0);
    assign sym_end    = (sym_cnt == SYM_LAST);
    assign data_ready = (state == IDLE) ||
                        ((state == DATA) && sym_end && (bit_idx == 3'd7));
    assign accept     = data_valid && data_ready;
    assign bit_nx     = bit_idx + 3'd1;

    always_comb begin
        next_state   = state;
        next_sym_cnt = sym_cnt;
        next_pre_cnt = pre_cnt;
        next_bit_idx = bit_idx;
        next_phase   = phase;
        next_shreg   = shreg;
        upd          = 1'b0;
        b_next       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state   = PREAMBLE;
                    next_shreg   = data_in;
                    next_sym_cnt = '0;
                    next_pre_cnt = '0;
                    next_phase   = 1'b0;
                end
            end
            PREAMBLE: begin
                if (sym_end) begin
                    next_sym_cnt = '0;
                    if (pre_cnt == PRE_LAST) begin
                        next_state   = DATA;
                        next_bit_idx = 3'd0;
                        upd          = 1'b1;
                        b_next       = shreg[0];
                    end else begin
                        next_pre_cnt = pre_cnt + 1'b1;
                        next_phase   = ~phase;
                    end
                end else begin
                    next_sym_cnt = sym_cnt + 1'b1;
                end
            end
            DATA: begin
                if (sym_end) begin
                    next_sym_cnt = '0;
                    next_bit_idx = bit_nx;
                    if (bit_idx != 3'd7) begin
                        upd    = 1'b1;
                        b_next = shreg[bit_nx];
                    end else if (accept) begin
                        // Follow-on byte: no preamble, phase carries over
                        next_shreg = data_in;
                        upd        = 1'b1;
                        b_next     = data_in[0];
                    end else begin
                        next_state   = IDLE;
                        next_phase   = 1'b0;
                        next_pre_cnt = '0;
                    end
                end else begin
                    next_sym_cnt = sym_cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
`ifdef PSK_DIFF_EN
        if (upd) next_phase = phase ^ b_next;
`else
        if (upd) next_phase = b_next;
`endif
        next_carrier = |((next_sym_cnt / HP) & SW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sym_cnt    <= '0;
            pre_cnt    <= '0;
            bit_idx    <= 3'd0;
            phase      <= 1'b0;
            shreg      <= 8'd0;
            psk_signal <= 1'b0;
        end else begin
            state      <= next_state;
            sym_cnt    <= next_sym_cnt;
            pre_cnt    <= next_pre_cnt;
            bit_idx    <= next_bit_idx;
            phase      <= next_phase;
            shreg      <= next_shreg;
            psk_signal <= (next_state != IDLE) && (next_carrier ^ next_phase);
        end
    end

endmodule

// File: tb/tb_psk_modulator.sv
// Self-checking bench for psk_modulator: offset-based reference model,
// directed timing/phase literals, then randomized traffic with resets.
module tb_psk_modulator;

    localparam int HP = 5;
    localparam int CPS = 2;
    localparam int P = 8;
    localparam int S = 2 * HP * CPS;
`ifdef PSK_DIFF_EN
    localparam bit DIFF = 1'b1;
    localparam logic [7:0] A5_PH = 8'h9C;
`else
    localparam bit DIFF = 1'b0;
    localparam logic [7:0] A5_PH = 8'hA5;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       psk_signal;
    logic       busy;
    logic       sym_strobe;

    psk_modulator #(
        .HALF_PERIOD   (HP),
        .CYCLES_PER_SYM(CPS),
        .PREAMBLE_SYMS (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .psk_signal(psk_signal),
        .busy      (busy),
        .sym_strobe(sym_strobe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    int strobe_cnt = 0;
    int busy_cnt = 0;

    // Model: cycle offset since burst start plus per-data-symbol phases
    bit m_busy;
    int m_t;
    bit m_ph[$];

    function automatic void chk(input string name, input logic act,
                                input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                     $time);
        end
    endfunction

    function automatic void chk_int(input string name, input int act,
                                    input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
                     $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        m_t = 0;
        m_ph.delete();
    endfunction

    function automatic void append_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
`ifdef PSK_DIFF_EN
            bit r;
            r = (m_ph.size() == 0) ? bit'((P - 1) % 2) : m_ph[m_ph.size()-1];
            m_ph.push_back(r ^ b[i]);
`else
            m_ph.push_back(b[i]);
`endif
        end
    endfunction

    function automatic void model_exp(output bit e_psk, output bit e_busy,
                                      output bit e_rdy, output bit e_stb);
        int sym, pos;
        bit car, ph;
        e_psk = 1'b0;
        e_busy = 1'b0;
        e_rdy = 1'b1;
        e_stb = 1'b0;
        if (m_busy) begin
            sym = m_t / S;
            pos = m_t % S;
            car = ((pos / HP) % 2) == 1;
            ph = (sym < P) ? bit'(sym % 2) : m_ph[sym-P];
            e_psk = car ^ ph;
            e_busy = 1'b1;
            e_stb = (pos == 0);
            e_rdy = (sym >= P) && (((sym - P) % 8) == 7) && (pos == S - 1);
        end
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] d);
        bit e_psk, e_busy, e_rdy, e_stb;
        model_exp(e_psk, e_busy, e_rdy, e_stb);
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                m_t = 0;
                m_ph.delete();
                append_byte(d);
            end
        end else if (e_rdy && !v) begin
            model_reset();
        end else begin
            if (e_rdy) append_byte(d);
            m_t++;
        end
    endfunction

    task automatic compare();
        bit e_psk, e_busy, e_rdy, e_stb;
        model_exp(e_psk, e_busy, e_rdy, e_stb);
        chk("psk_signal", psk_signal, e_psk);
        chk("busy", busy, e_busy);
        chk("data_ready", data_ready, e_rdy);
        chk("sym_strobe", sym_strobe, e_stb);
        strobe_cnt += int'(sym_strobe);
        busy_cnt += int'(busy);
    endtask

    // One clock: drive, compare at negedge, clock edge, advance model
    task automatic cyc(input bit v, input logic [7:0] d);
        data_valid = v;
        data_in = d;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        edge_n++;
        model_step(v, d);
    endtask

    task automatic run(input int n, input bit v, input logic [7:0] d);
        for (int i = 0; i < n; i++) cyc(v, d);
    endtask

    task automatic run_idle();
        int k;
        k = 0;
        while (m_busy && k < 2000) begin
            cyc(1'b0, 8'h00);
            k++;
        end
        if (m_busy) chk("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_psk"}, psk_signal, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ready"}, data_ready, 1'b1);
        chk({tag, "_strobe"}, sym_strobe, 1'b0);
    endtask

    initial begin
        logic [7:0] a5;
        a5 = A5_PH;
        rst_n = 1'b0;
        data_valid = 1'b1;
        data_in = 8'h5A;
        model_reset();

        @(posedge clk);
        #1;
        chk_reset_outs("rst");
        cyc(1'b1, 8'h5A);
        rst_n = 1'b1;
        cyc(1'b1, 8'h5A);
        chk("first_accept_busy", busy, 1'b1);
        chk("first_accept_strobe", sym_strobe, 1'b1);
        run_idle();

        // Single byte 0x00
        strobe_cnt = 0;
        busy_cnt = 0;
        cyc(1'b1, 8'h00);
        run(4, 1'b0, 8'h00);
        chk("pre_start_low", psk_signal, 1'b0);
        run(1, 1'b0, 8'h00);
        chk("pre_rise_t5", psk_signal, 1'b1);
        run(155, 1'b0, 8'h00);
        chk("byte00_first_data", psk_signal, DIFF);
        run(159, 1'b0, 8'h00);
        chk("t319_busy", busy, 1'b1);
        chk("t319_ready", data_ready, 1'b1);
        run(1, 1'b0, 8'h00);
        chk("t320_busy", busy, 1'b0);
        chk("t320_ready", data_ready, 1'b1);
        chk_int("byte00_strobes", strobe_cnt, 16);
        chk_int("byte00_busy_cycles", busy_cnt, 320);

        // Single byte 0xFF
        cyc(1'b1, 8'hFF);
        run(160, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("byteFF_sym_phase", psk_signal, DIFF ? bit'(i % 2) : 1'b1);
            run(20, 1'b0, 8'h00);
        end
        chk("byteFF_done", busy, 1'b0);

        // Back-to-back 0xA5 then 0x3C
        strobe_cnt = 0;
        busy_cnt = 0;
        cyc(1'b1, 8'hA5);
        run(160, 1'b1, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            chk("byteA5_sym_phase", psk_signal, a5[i]);
            run(20, 1'b1, 8'h3C);
        end
        chk("b2b_busy_t320", busy, 1'b1);
        chk("b2b_strobe_t320", sym_strobe, 1'b1);
        chk_int("b2b_model_bits", m_ph.size(), 16);
        run_idle();
        chk_int("b2b_busy_cycles", busy_cnt, 480);
        chk_int("b2b_strobes", strobe_cnt, 24);

        // Mid-byte reset during bit 3, then a full preamble again
        cyc(1'b1, 8'h66);
        run(225, 1'b0, 8'h00);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outs("async_rst");
        cyc(1'b0, 8'h00);
        rst_n = 1'b1;
        cyc(1'b1, 8'h81);
        run(125, 1'b0, 8'h00);
        chk("rerun_sym6", psk_signal, 1'b1);
        run(20, 1'b0, 8'h00);
        chk("rerun_sym7", psk_signal, 1'b0);
        run_idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                cyc(1'b0, 8'h00);
                rst_n = 1'b1;
            end else begin
                cyc($urandom_range(0, 3) == 0, 8'($urandom));
            end
        end
        run_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks,
                 n_errors);
        $finish;
    end

endmodule

// File: doc/psk_modulator.md
# psk_modulator

Upstream transmit stage of the PSK link. It accepts parallel bytes over a valid/ready handshake and serialises them onto a square-wave carrier as binary phase-shift keying on `psk_signal`, the single-bit line that the PSK decoder with clock detection consumes. Each burst opens with an alternating-phase preamble so the decoder can lock its clock estimate before data arrives.

## Interface
- `HALF_PERIOD`, default 5: clk cycles per carrier half-cycle; must be ≥1.
- `CYCLES_PER_SYM`, default 2: full carrier cycles per symbol; must be ≥1.
  - Symbol length: SYM_LEN = 2·HALF_PERIOD·CYCLES_PER_SYM clk cycles (20 at defaults).
- `PREAMBLE_SYMS`, default 8: preamble symbols per burst; must be ≥1.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in 8: byte to transmit; sent LSB first.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: block accepts a byte this cycle.
- `psk_signal` out 1: modulated output, registered; feeds the decoder's `psk_signal`.
- `busy` out 1: high when state ≠ IDLE.
- `sym_strobe` out 1: one-cycle pulse on the first cycle of every preamble and data symbol.

## Operation
- **States:** IDLE, PREAMBLE, DATA.
- **Registers:**
  - `sym_cnt`: 0..SYM_LEN-1.
  - `pre_cnt`: 0..PREAMBLE_SYMS-1.
  - `bit_idx`: 0..7.
  - `phase`: 1 bit.
  - `shreg`: 8 bits.
- **Carrier:** `carrier = (sym_cnt / HALF_PERIOD) & 1`. It is low on the first half-cycle of every symbol. Every symbol holds an even number of half-cycles, so the carrier is phase-continuous across symbol boundaries.
- **Output:** `psk_signal <= next_carrier ^ next_phase`, computed from the next-state values. It is held 0 in IDLE.
- **Accept:** a transfer occurs on an edge where `data_valid && data_ready`.
  - `data_ready` is 1 in IDLE.
  - In DATA, `data_ready` is 1 only on the last cycle of bit 7 (`sym_cnt==SYM_LEN-1`, `bit_idx==7`).
  - `data_ready` is 0 at all other times.
  - `data_in` is ignored when no transfer occurs.
- **IDLE → PREAMBLE on accept:** load `shreg`, `sym_cnt=0`, `pre_cnt=0`, `phase=0`.
- **PREAMBLE:**
  - Preamble symbol k has `phase = k & 1`, i.e. the phase toggles at every symbol boundary.
  - After the last cycle of symbol PREAMBLE_SYMS-1, go to DATA with `bit_idx=0`.
- **DATA:**
  - At each symbol start, update the phase from `b = shreg[bit_idx]` (see Configuration).
  - After the last cycle of bit 7:
    - If a transfer occurs, load the new byte and stay in DATA with `bit_idx=0`. There is no preamble, and `phase` continues.
    - If no transfer occurs, go to IDLE, `phase=0`, and `psk_signal` goes to 0 on that edge.
- **Reset:** while `rst_n` is low, regardless of state:
  - state=IDLE; all counters, `phase` and `shreg` are 0.
  - `psk_signal=0`, `busy=0`, `sym_strobe=0`, `data_ready=1`.
  - An in-flight byte is discarded. The next burst restarts with a full preamble.

## Timing
- **Accepting edge T:** `busy` = 1 and `sym_strobe` = 1 for the cycle following T.
- **Preamble start:** at defaults, `psk_signal` rises at edge T+5 (HALF_PERIOD).
- **Preamble length:** PREAMBLE_SYMS·SYM_LEN cycles; 160 at defaults.
- **Byte length:** 8·SYM_LEN cycles; 160 at defaults.
- **Single byte at defaults:** `busy` falls at edge T+320, and `data_ready` returns high in the same cycle.
- **Back-to-back:** the follow-on byte is accepted at edge T+PREAMBLE_SYMS·SYM_LEN+8·SYM_LEN, i.e. T+320 at defaults for the second byte of a burst. There is no gap cycle; `busy` stays high.
- **Strobe rate:** `sym_strobe` fires exactly once every SYM_LEN cycles while busy.

## Configuration
- **`PSK_DIFF_EN` defined:** differential encoding, `phase <= phase ^ b`.
  - 1 = phase inversion, 0 = no change.
  - The reference phase for the first data bit is that of the last preamble symbol, `(PREAMBLE_SYMS-1) & 1`.
- **`PSK_DIFF_EN` undefined:** absolute BPSK, `phase <= b`.
  - The preamble is unchanged.

## Test plan
- **Reset:** hold `rst_n`=0 with `data_valid`=1 → `psk_signal`=0, `busy`=0, `data_ready`=1, `sym_strobe`=0. After release with `data_valid` held, the byte is accepted on the first edge.
- **Single byte 0x00, `PSK_DIFF_EN`, defaults:**
  - 8 preamble symbols with alternating phase, `sym_strobe` every 20 cycles.
  - All 8 data symbols at phase 1, so `psk_signal` = inverted carrier.
  - `busy` low at T+320.
- **Single byte 0xFF, `PSK_DIFF_EN`:** data phases 0,1,0,1,0,1,0,1.
  - `psk_signal` inverts at every data symbol boundary.
- **Back-to-back 0xA5 then 0x3C, `data_valid` held:**
  - Second accept at T+320 with no second preamble.
  - `busy` high continuously for 480 cycles; 24 strobes total.
- **Mid-byte reset:** assert `rst_n`=0 during bit 3 → outputs reset asynchronously. The next byte produces the full 160-cycle preamble again.
- **Absolute mode (`PSK_DIFF_EN` undefined), byte 0xA5:** data phases 1,0,1,0,0,1,0,1.
  - `psk_signal` equals carrier XOR phase at every cycle.
